// File: rtl/packer_if.sv
// packer_if: operand/result handshake bundle for the packer.
//   in_data   Q2.30 operand           in_valid / in_ready   operand handshake
//   out_data  IEEE-754 single result  out_valid / out_ready result handshake
//   master modport drives operands and accepts results; slave is the packer side.
interface packer_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/packer.sv
// packer: converts one signed Q2.30 fixed-point value to IEEE-754 single precision.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; discards any operand in flight
//   bus    packer_if.slave: in_data/in_valid/in_ready, out_data/out_valid/out_ready
// Define PACKER_ROUND_EN for round-to-nearest-even; otherwise the significand is truncated.
module packer (
    input  logic     clk,
    input  logic     reset,
    packer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, OUT} state_t;
    state_t      state, state_n;
    logic [31:0] mag, abs_mag, data_q;
    logic        sign, inc;
    logic [5:0]  s;
    logic [7:0]  exp_b, exp_r;
    logic [24:0] sig_r;

    // In ABS, mag still holds the raw operand; 0x80000000 negates to itself.
    assign abs_mag       = mag[31] ? -mag : mag;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == OUT;
    assign bus.out_data  = data_q;
    assign exp_b         = 8'd128 - {2'b00, s};
`ifdef PACKER_ROUND_EN
    assign inc = mag[7] & (|mag[6:0] | mag[8]);
`else
    assign inc = 1'b0;
`endif
    // A carry out of the 24-bit significand leaves a zero fraction and bumps the exponent.
    assign sig_r = {1'b0, mag[31:8]} + {24'd0, inc};
    assign exp_r = exp_b + {7'd0, sig_r[24]};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.in_valid ? ABS : IDLE;
            ABS:     state_n = abs_mag == 32'd0 ? OUT : abs_mag[31] ? ROUND : NORM;
            NORM:    state_n = mag[30] ? ROUND : NORM;
            ROUND:   state_n = OUT;
            OUT:     state_n = bus.out_ready ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag    <= 32'd0;
            s      <= 6'd0;
            sign   <= 1'b0;
            data_q <= 32'd0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) mag <= bus.in_data;
                ABS: begin
                    sign <= mag[31];
                    mag  <= abs_mag;
                    s    <= 6'd0;
                    if (abs_mag == 32'd0) data_q <= 32'd0;
                end
                NORM: begin
                    mag <= mag << 1;
                    s   <= s + 6'd1;
                end
                ROUND: data_q <= {sign, exp_r, sig_r[22:0]};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_packer.sv
// tb_packer: scoreboard bench for packer; directed vectors, random operands,
// output-hold and reset-mid-conversion scenarios.
module tb_packer;
    logic clk = 1'b0;
    logic reset;
    logic auto_rdy = 1'b1;
    int   total = 0, bad = 0, cyc = 0;

    packer_if ifc();
    packer dut (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) ifc.out_ready = auto_rdy ? ($urandom_range(0, 3) != 0) : 1'b0;

    typedef struct {
        logic [31:0] d;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    // Value = x * 2^-30; leading one at bit p gives biased exponent 127 + (p - 30).
    function automatic void ref_model(input logic [31:0] x, output logic [31:0] d, output int lat);
        logic [31:0] m;
        logic [63:0] f;
        logic [24:0] sig;
        logic [7:0]  ex;
        int          p;
        m = x[31] ? -x : x;
        d = 32'd0;
        lat = 2;
        if (m == 32'd0) return;
        p = 31;
        while (!m[p]) p--;
        f = {32'd0, m} << (63 - p);
        sig = {1'b0, f[63:40]};
`ifdef PACKER_ROUND_EN
        if (f[39:0] > 40'h80_0000_0000 || (f[39:0] == 40'h80_0000_0000 && sig[0])) sig = sig + 25'd1;
`endif
        ex = 8'(97 + p);
        if (sig[24]) ex = ex + 8'd1;
        d = {x[31], ex, sig[22:0]};
        lat = 34 - p;
    endfunction

    logic        pv = 1'b0;
    logic [31:0] pd;
    always @(negedge clk) begin
        exp_t e;
        if (reset) pv = 1'b0;
        else begin
            if (ifc.out_valid && !pv) begin
                if (sb.size() == 0) timeout("spurious_out");
                else begin
                    e = sb.pop_front();
                    chk("data", ifc.out_data, e.d);
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end else if (ifc.out_valid) chk("out_stable", ifc.out_data, pd);
            pv = ifc.out_valid;
            pd = ifc.out_data;
        end
    end

    // Called at a negedge; junk in_valid while busy must be ignored.
    task automatic send(input logic [31:0] x, input logic [31:0] d, input int lat);
        for (int n = 0; n < 300; n++) begin
            if (ifc.in_ready) begin
                ifc.in_valid = 1'b1;
                ifc.in_data = x;
                sb.push_back('{d, cyc + 1, lat});
                @(negedge clk);
                ifc.in_valid = 1'b0;
                ifc.in_data = $urandom;
                return;
            end
            ifc.in_valid = 1'($urandom_range(0, 1));
            ifc.in_data = $urandom;
            @(negedge clk);
        end
        timeout("send");
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0 && ifc.in_ready) return;
            @(negedge clk);
        end
        timeout("drain");
    endtask

    logic [31:0] din[9]  = '{32'h40000000, 32'h26DD3B80, 32'hC0000000, 32'h80000000, 32'h00000000,
                             32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h20000000};
`ifdef PACKER_ROUND_EN
    logic [31:0] dout[9] = '{32'h3F800000, 32'h3F1B74EE, 32'hBF800000, 32'hC0000000, 32'h00000000,
                             32'h30800000, 32'h40000000, 32'hB0800000, 32'h3F000000};
`else
    logic [31:0] dout[9] = '{32'h3F800000, 32'h3F1B74EE, 32'hBF800000, 32'hC0000000, 32'h00000000,
                             32'h30800000, 32'h3FFFFFFF, 32'hB0800000, 32'h3F000000};
`endif
    int dlat[9] = '{4, 5, 4, 3, 2, 34, 4, 34, 5};

    initial begin
        logic [31:0] x, d, hd;
        int          lat;
        reset = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("reset_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("reset_out_data", ifc.out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) send(din[i], dout[i], dlat[i]);
        for (int i = 0; i < 150; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 15) == 0) x = 32'd0;
            ref_model(x, d, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(x, d, lat);
        end
        drain();
        auto_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        send(32'h40000000, 32'h3F800000, 4);
        for (int n = 0; n < 50 && !ifc.out_valid; n++) @(negedge clk);
        chk("hold_reached", 32'(ifc.out_valid), 32'd1);
        hd = ifc.out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ifc.out_valid), 32'd1);
            chk("hold_data", ifc.out_data, hd);
            chk("hold_in_ready", 32'(ifc.in_ready), 32'd0);
        end
        auto_rdy = 1'b1;
        drain();
        send(32'h00000001, 32'h30800000, 34);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("midreset_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("midreset_out_data", ifc.out_data, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        send(32'hC0000000, 32'hBF800000, 4);
        send(32'h26DD3B80, 32'h3F1B74EE, 5);
        drain();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d", total);
        $fatal(1, "simulation did not finish");
    end
endmodule
